// File: rtl/board_generator_if.sv
// Handshake between the tile renderer (master) and the board generator (slave):
// first-click pulse in, finished board out.
interface board_generator_if #(
  parameter int TOTAL_TILES = 64,
  parameter int IDX_W       = $clog2(TOTAL_TILES)
);
  logic                     start;
  logic [IDX_W-1:0]         start_index;
  logic [TOTAL_TILES-1:0]   mine_map;
  logic [TOTAL_TILES*4-1:0] adj;
  logic                     game_ready;
  logic                     busy;

  modport master (output start, start_index, input mine_map, adj, game_ready, busy);
  modport slave  (input start, start_index, output mine_map, adj, game_ready, busy);
endinterface

// File: rtl/board_generator.sv
// Places NUM_MINES mines with an LFSR, keeping the first-clicked 3x3 area clear,
// then walks every tile once to compute its mined-neighbour count.
module board_generator #(
  parameter int          GRID_SIZE   = 8,
  parameter int          TOTAL_TILES = GRID_SIZE * GRID_SIZE,
  parameter int          NUM_MINES   = 10,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  board_generator_if.slave bus
);
  localparam int          IDX_W     = $clog2(TOTAL_TILES);
  localparam int          CNT_W     = $clog2(NUM_MINES + 1);
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, PLACE, ADJ, READY} state_t;

  state_t                   state, state_next;
  logic [15:0]              lfsr, lfsr_next;
  logic [TOTAL_TILES-1:0]   mine_map_q;
  logic [TOTAL_TILES*4-1:0] adj_q;
  logic [CNT_W-1:0]         mine_cnt;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         safe_row, safe_col;
  logic [IDX_W-1:0]         cand;
  logic                     start_ok, accept;
  logic [3:0]               nbr_cnt;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign cand      = lfsr[IDX_W-1:0];
  assign start_ok  = bus.start && (int'(bus.start_index) < TOTAL_TILES);

  always_comb begin
    int dr, dc;
    // NOTE: every combinational output gets a value before any branch so no latch is inferred.
    accept = 1'b0;
    dr     = int'(cand) / GRID_SIZE - int'(safe_row);
    dc     = int'(cand) % GRID_SIZE - int'(safe_col);
    if (int'(cand) < TOTAL_TILES && !(dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1))
      accept = !mine_map_q[cand];
  end

  // Neighbour count of the tile under the ADJ pointer; off-grid neighbours are skipped, never wrapped.
  always_comb begin
    int prow, pcol;
    nbr_cnt = '0;
    prow    = int'(ptr) / GRID_SIZE;
    pcol    = int'(ptr) % GRID_SIZE;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && prow + dr >= 0 && prow + dr < GRID_SIZE &&
            pcol + dc >= 0 && pcol + dc < GRID_SIZE) begin
          if (mine_map_q[(prow + dr) * GRID_SIZE + pcol + dc]) nbr_cnt = nbr_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = PLACE;
      PLACE:   if (accept && mine_cnt == CNT_W'(NUM_MINES - 1)) state_next = ADJ;
      ADJ:     if (int'(ptr) == TOTAL_TILES - 1) state_next = READY;
      default: state_next = state;
    endcase
  end

  always_comb begin
    bus.busy       = (state == PLACE) || (state == ADJ);
    bus.game_ready = (state == READY);
  end

  always_ff @(posedge clk) begin
    // NOTE: the board storage is reset on purpose; downstream reads all-zero until a new board is built.
    if (!rst) begin
      lfsr       <= LFSR_INIT;
      mine_map_q <= '0;
      adj_q      <= '0;
      mine_cnt   <= '0;
      ptr        <= '0;
      safe_row   <= '0;
      safe_col   <= '0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          if (start_ok) begin
            safe_row   <= IDX_W'(int'(bus.start_index) / GRID_SIZE);
            safe_col   <= IDX_W'(int'(bus.start_index) % GRID_SIZE);
            mine_map_q <= '0;
            mine_cnt   <= '0;
            ptr        <= '0;
          end
        end
        PLACE: begin
          if (accept) begin
            mine_map_q[cand] <= 1'b1;
            mine_cnt         <= mine_cnt + 1'b1;
          end
          ptr <= '0;
        end
        ADJ: begin
          adj_q[int'(ptr) * 4 +: 4] <= nbr_cnt;
          ptr                       <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mine_map = mine_map_q;
  assign bus.adj      = adj_q;
endmodule

// File: tb/tb_board_generator.sv
// Directed bench: three generators (seeds ACE1, 1234, 0) share clock, reset and the
// first-click pulse; each board is compared against a bench-side placement/adjacency model.
module tb_board_generator;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] start_index = '0;

  always #5 clk = ~clk;

  board_generator_if bus_a ();
  board_generator_if bus_b ();
  board_generator_if bus_c ();

  assign bus_a.start = start;  assign bus_a.start_index = start_index;
  assign bus_b.start = start;  assign bus_b.start_index = start_index;
  assign bus_c.start = start;  assign bus_c.start_index = start_index;

  board_generator u_a (.clk(clk), .rst(rst), .bus(bus_a));
  board_generator #(.SEED(16'h1234)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  board_generator #(.SEED(16'h0000)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [63:0]  mm  [N];
  logic [255:0] av  [N];
  logic         rdy [N];
  logic         bsy [N];

  assign mm[0] = bus_a.mine_map; assign av[0] = bus_a.adj; assign rdy[0] = bus_a.game_ready; assign bsy[0] = bus_a.busy;
  assign mm[1] = bus_b.mine_map; assign av[1] = bus_b.adj; assign rdy[1] = bus_b.game_ready; assign bsy[1] = bus_b.busy;
  assign mm[2] = bus_c.mine_map; assign av[2] = bus_c.adj; assign rdy[2] = bus_c.game_ready; assign bsy[2] = bus_c.busy;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  exp_mm [N];
  logic [255:0] exp_av [N];
  int           exp_p  [N];
  int           lat    [N];
  int           cur_idx;
  logic [63:0]  keep_mm;
  logic [255:0] keep_av;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] seed_of(input int i);
    case (i)
      0:       return 16'hACE1;
      1:       return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [63:0] safe_mask(input int idx);
    logic [63:0] m = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (r - idx / 8 >= -1 && r - idx / 8 <= 1 && c - idx % 8 >= -1 && c - idx % 8 <= 1)
          m[r * 8 + c] = 1'b1;
    return m;
  endfunction

  // Reference board: n LFSR shifts up to and including the start edge, then one candidate per cycle.
  task automatic model_board(input logic [15:0] seed, input int n, input int idx,
                             output logic [63:0] m, output logic [255:0] a, output int cyc);
    logic [15:0] l;
    int cnt, c, nb;
    l = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int j = 0; j < n; j++) l = lfsr_step(l);
    m = '0; cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 20000) begin
      c = int'(l[5:0]);
      if (!safe_mask(idx)[c] && !m[c]) begin
        m[c] = 1'b1;
        cnt++;
      end
      cyc++;
      l = lfsr_step(l);
    end
    a = '0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && k + dc >= 0 && k + dc < 8)
              if (m[(r + dr) * 8 + k + dc]) nb++;
        a[(r * 8 + k) * 4 +: 4] = 4'(nb);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Start edge is the (w+1)-th edge with reset released.
  task automatic start_run(input int w, input int idx);
    repeat (w) @(posedge clk);
    @(negedge clk);
    start       = 1'b1;
    start_index = 6'(idx);
    cur_idx     = idx;
    for (int i = 0; i < N; i++) model_board(seed_of(i), w + 1, idx, exp_mm[i], exp_av[i], exp_p[i]);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("busy_rise%0d", i), 256'(bsy[i]), 256'(1));
  endtask

  // k counts clock edges after the start edge; abort_k >= 0 returns early at that edge count.
  task automatic wait_ready(input bit pulses, input int abort_k);
    int  k = 0;
    bit  all;
    for (int i = 0; i < N; i++) lat[i] = -1;
    while (k < 2000) begin
      all = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (lat[i] < 0 && rdy[i]) lat[i] = k;
        if (lat[i] < 0) all = 1'b0;
      end
      if (all) break;
      if (abort_k >= 0 && k == abort_k) return;
      start       = pulses && (k == 2 || k == exp_p[0] + 5);
      start_index = 6'd63;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic check_boards(input string name);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_lat%0d", name, i), 256'(lat[i]), 256'(exp_p[i] + 64));
      check($sformatf("%s_mm%0d", name, i), 256'(mm[i]), 256'(exp_mm[i]));
      check($sformatf("%s_adj%0d", name, i), av[i], exp_av[i]);
      check($sformatf("%s_pop%0d", name, i), 256'($countones(mm[i])), 256'(10));
      check($sformatf("%s_safe%0d", name, i), 256'(mm[i] & safe_mask(cur_idx)), 256'(0));
      check($sformatf("%s_rdy%0d", name, i), 256'(rdy[i]), 256'(1));
      check($sformatf("%s_busy%0d", name, i), 256'(bsy[i]), 256'(0));
    end
  endtask

  initial begin
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        check($sformatf("idle%0d", i), {mm[i], av[i][191:0]} | 256'(av[i][255:192]), 256'(0));
      check("idle_flags", 256'({rdy[0], bsy[0], rdy[1], bsy[1], rdy[2], bsy[2]}), 256'(0));
    end

    // Corner first click: tiles 0,1,8,9 stay clear.
    do_reset();
    start_run(4, 0);
    wait_ready(1'b0, -1);
    check_boards("r1");

    // Centre first click with stray pulses in PLACE, ADJ and READY.
    do_reset();
    start_run(11, 27);
    wait_ready(1'b1, -1);
    check_boards("r2");
    keep_mm = mm[1];
    keep_av = av[1];
    @(negedge clk);
    start = 1'b1; start_index = 6'd63;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_boards("r2_post");

    // Reset mid-ADJ, then regenerate from the far corner.
    do_reset();
    start_run(11, 0);
    wait_ready(1'b0, exp_p[0] + 20);
    check("r3_midadj_busy", 256'({bsy[0], rdy[0]}), 256'(2'b10));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("r3_rst%0d", i), {mm[i], av[i][191:0]} | 256'({av[i][255:192], rdy[i], bsy[i]}), 256'(0));
    rst = 1'b1;
    start_run(7, 63);
    wait_ready(1'b0, -1);
    check_boards("r3");

    // Same seed and start timing as r2 must give the same board.
    do_reset();
    start_run(11, 27);
    wait_ready(1'b0, -1);
    check_boards("r4");
    check("det_mm", 256'(mm[1]), 256'(keep_mm));
    check("det_adj", av[1], keep_av);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
